stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

- Consumes the 16-bit preset value from the loader stage and holds the live stopwatch time as packed BCD MM:SS.
- Counts up or down once per 1 Hz tick and halts at the terminal value for the current direction.
- Adds a BCD minute offset through a two-cycle sequenced add.
- Drives the display/decoder stage downstream.

## Interface
Parameters:
- MIN_MAX, 8'h59, BCD ceiling for minutes (saturation and up-count terminal).
- SEC_MAX, 8'h59, BCD ceiling for seconds.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- Sreset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle 1 Hz step strobe, synchronous to clk.
- run  in  1  level; 1 = count, 0 = pause.
- reverse  in  1  level; 0 = count up, 1 = count down; sampled at each tick.
- load  in  1  one-cycle strobe; load load_value.
- load_value  in  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each, BCD.
- add_req  in  1  one-cycle strobe; add add_min to minutes.
- add_min  in  8  BCD minutes {tens, ones}, latched on add_req.
- time_bcd  out  16  current time; same packing as load_value.
- running  out  1  1 while state is RUN.
- done  out  1  one-cycle pulse on entering HALT.
- add_busy  out  1  1 during ADD1/ADD2.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, HALT, ADD1, ADD2. Reset: state IDLE; time_bcd 16'h0000; running, done, add_busy, load_err all 0; pending-tick flag 0.
- Priority per edge: load > add_req > tick.
- Load, accepted in any state except ADD1/ADD2:
  - Valid value: time_bcd = load_value, state -> IDLE.
  - Invalid value (any digit >9, sec_tens >5, or minutes >MIN_MAX): time unchanged, state unchanged, load_err pulse.
  - Load during ADD1/ADD2: ignored, no load_err.
- IDLE:
  - run=1 -> RUN.
  - Ticks are ignored.
- RUN:
  - run=0 -> IDLE.
  - On tick, terminal is MIN_MAX:SEC_MAX if reverse=0, else 00:00.
  - If time already equals the terminal: no change, -> HALT, done.
  - Otherwise step one second. Seconds wrap 59->00 with carry into minutes; 00->59 with borrow from minutes.
  - If the new value equals the terminal: -> HALT, done on the same edge.
- HALT:
  - Time frozen; run and tick ignored.
  - Exits only via load (-> IDLE) or add (-> ADD1).
- Add sequence, accepted in IDLE/RUN/HALT:
  - On add_req: latch add_min and the return state, -> ADD1.
  - ADD1: minute ones += add_ones (BCD, carry out).
  - ADD2: minute tens += add_tens + carry. If the result exceeds MIN_MAX, minutes = MIN_MAX; seconds always unchanged.
  - After ADD2 return to the latched state, except return from HALT goes to IDLE.
  - add_min with any digit >9: sequence still runs, result is minutes saturated to MIN_MAX.
- Tick during ADD1/ADD2 sets the pending flag. The flag is applied as a normal RUN tick on the first cycle after return, if the return state is RUN; otherwise it is discarded. Multiple ticks during an add collapse to one.
- A reverse change while running takes effect at the next tick.

## Timing
- tick -> time_bcd update: 1 edge; visible the cycle after tick.
- done is registered and coincides with the first cycle time_bcd shows the terminal value (or the first HALT cycle).
- add_req -> add_busy high next cycle for exactly 2 cycles. Final minutes are visible on the cycle add_busy falls.
- load -> time_bcd valid next cycle. load_err pulses the cycle after a rejected load.
- running rises the cycle after run=1 is sampled in IDLE, and falls the cycle after run=0 or HALT entry.
- Sreset mid-add aborts the sequence and the pending tick; outputs take their reset values immediately.

## Test plan
- Reset, load 16'h1020, run=1, reverse=1, 3 ticks -> time 10:17; running=1; done=0.
- Load 16'h0002, reverse=1, run, 2 ticks -> 00:01, then 00:00 with done pulse on that cycle; further ticks leave 00:00, state HALT.
- Load 16'h4959, reverse=0, run, 1 tick -> 50:00 (seconds wrap with minute carry); load 16'h5958 then 1 tick -> 59:59 with done.
- In RUN at 12:30, add_req with add_min=8'h48 and a tick during ADD1 -> add_busy 2 cycles, minutes 59 (saturated 60->59), then pending tick gives 59:31.
- load 16'h1A00 -> load_err pulse, time unchanged. load and add_req on the same edge with 16'h0500 -> time 05:00, add_busy stays 0.
- Sreset asserted asynchronously mid-ADD2 -> time_bcd 0000, add_busy 0, state IDLE before the next clk edge.

Source files
------------

// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
// Packed-BCD MM:SS stopwatch. It counts up or down once per 1 Hz tick and
// halts at the terminal value for the current direction. A preset can be
// loaded, and a BCD minute offset can be added through a two-cycle sequence.
//
// State table
//   state | meaning
//   IDLE  | paused, ticks ignored, run=1 starts counting
//   RUN   | stepping one second per tick
//   HALT  | terminal reached, frozen until load or add
//   ADD1  | minute ones += offset ones (BCD carry latched)
//   ADD2  | minute tens += offset tens + carry, saturate to MIN_MAX
//
// Ports
//   clk         system clock, rising edge
//   Sreset      asynchronous active-high reset
//   tick        1 Hz step strobe (one clk wide)
//   run         level: 1 = count, 0 = pause
//   reverse     level: 0 = up, 1 = down
//   load        strobe: load load_value
//   load_value  {min_tens, min_ones, sec_tens, sec_ones} BCD
//   add_req     strobe: add add_min to minutes
//   add_min     BCD minutes {tens, ones}
//   time_bcd    current time, same packing as load_value
//   running     1 while in RUN
//   done        one-cycle pulse on HALT entry
//   add_busy    1 during ADD1/ADD2
//   load_err    one-cycle pulse on a rejected load
// ---------------------------------------------------------------------------
module stopwatch_counter #(
    parameter logic [7:0] MIN_MAX = 8'h59,
    parameter logic [7:0] SEC_MAX = 8'h59
) (
    input  logic        clk,
    input  logic        Sreset,
    input  logic        tick,
    input  logic        run,
    input  logic        reverse,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        add_req,
    input  logic [7:0]  add_min,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done,
    output logic        add_busy,
    output logic        load_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_HALT = 3'd2;
    localparam logic [2:0] S_ADD1 = 3'd3;
    localparam logic [2:0] S_ADD2 = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  r_ret;
    logic [15:0] r_time;
    logic [7:0]  r_add_min;
    logic        r_carry;
    logic        r_pend;
    logic        r_done;
    logic        r_load_err;

    logic        w_load_ok;
    logic [15:0] w_up;
    logic [15:0] w_dn;
    logic [15:0] w_term;
    logic [15:0] w_stepped;
    logic        w_tick_eff;
    logic [4:0]  w_ones_sum;
    logic [3:0]  w_ones_new;
    logic        w_ones_carry;
    logic [4:0]  w_tens_sum;
    logic        w_sat;
    logic [7:0]  w_min_new;

    assign w_load_ok = (load_value[15:12] <= 4'd9) && (load_value[11:8] <= 4'd9) &&
                       (load_value[7:4]   <= 4'd5) && (load_value[3:0]  <= 4'd9) &&
                       (load_value[15:8] <= MIN_MAX) && (load_value[7:0] <= SEC_MAX);

    // one-second increment with seconds wrap 59->00 and minute carry
    always_comb begin
        w_up = r_time;
        if (r_time[3:0] != 4'd9) begin
            w_up[3:0] = r_time[3:0] + 4'd1;
        end else if (r_time[7:4] != 4'd5) begin
            w_up[7:4] = r_time[7:4] + 4'd1;
            w_up[3:0] = 4'd0;
        end else begin
            w_up[7:0] = 8'h00;
            if (r_time[11:8] != 4'd9) begin
                w_up[11:8] = r_time[11:8] + 4'd1;
            end else begin
                w_up[15:12] = r_time[15:12] + 4'd1;
                w_up[11:8]  = 4'd0;
            end
        end
    end

    // one-second decrement with seconds wrap 00->59 and minute borrow
    always_comb begin
        w_dn = r_time;
        if (r_time[3:0] != 4'd0) begin
            w_dn[3:0] = r_time[3:0] - 4'd1;
        end else if (r_time[7:4] != 4'd0) begin
            w_dn[7:4] = r_time[7:4] - 4'd1;
            w_dn[3:0] = 4'd9;
        end else begin
            w_dn[7:0] = 8'h59;
            if (r_time[11:8] != 4'd0) begin
                w_dn[11:8] = r_time[11:8] - 4'd1;
            end else begin
                w_dn[15:12] = r_time[15:12] - 4'd1;
                w_dn[11:8]  = 4'd9;
            end
        end
    end

    assign w_term     = reverse ? 16'h0000 : {MIN_MAX, SEC_MAX};
    assign w_stepped  = reverse ? w_dn : w_up;
    // r_pend can only be set here on the first cycle back in RUN after an add
    assign w_tick_eff = tick | r_pend;

    always_comb begin
        w_ones_sum   = {1'b0, r_time[11:8]} + {1'b0, r_add_min[3:0]};
        w_ones_carry = 1'b0;
        w_ones_new   = w_ones_sum[3:0];
        if (w_ones_sum > 5'd9) begin
            w_ones_carry = 1'b1;
            w_ones_new   = 4'(w_ones_sum - 5'd10);
        end
    end

    // any non-BCD offset digit or a tens overflow forces saturation
    assign w_tens_sum = {1'b0, r_time[15:12]} + {1'b0, r_add_min[7:4]} + {4'd0, r_carry};
    assign w_sat      = (r_add_min[7:4] > 4'd9) || (r_add_min[3:0] > 4'd9) ||
                        (w_tens_sum > 5'd9) || ({w_tens_sum[3:0], r_time[11:8]} > MIN_MAX);
    assign w_min_new  = w_sat ? MIN_MAX : {w_tens_sum[3:0], r_time[11:8]};

    always_ff @(posedge clk or posedge Sreset) begin
        if (Sreset) begin
            r_state    <= S_IDLE;
            r_ret      <= S_IDLE;
            r_time     <= 16'h0000;
            r_add_min  <= 8'h00;
            r_carry    <= 1'b0;
            r_pend     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            case (r_state)
                S_ADD1: begin
                    if (tick) r_pend <= 1'b1;
                    r_time[11:8] <= w_ones_new;
                    r_carry      <= w_ones_carry;
                    r_state      <= S_ADD2;
                end
                S_ADD2: begin
                    r_time[15:8] <= w_min_new;
                    r_state      <= (r_ret == S_HALT) ? S_IDLE : r_ret;
                    // a tick caught during the add survives only into RUN
                    r_pend       <= (r_pend | tick) && (r_ret == S_RUN);
                end
                default: begin
                    r_pend <= 1'b0;
                    if (load) begin
                        if (w_load_ok) begin
                            r_time  <= load_value;
                            r_state <= S_IDLE;
                        end else begin
                            r_load_err <= 1'b1;
                        end
                    end else if (add_req) begin
                        r_add_min <= add_min;
                        r_ret     <= r_state;
                        r_carry   <= 1'b0;
                        r_state   <= S_ADD1;
                    end else begin
                        case (r_state)
                            S_IDLE: begin
                                if (run) r_state <= S_RUN;
                            end
                            S_RUN: begin
                                if (!run) begin
                                    r_state <= S_IDLE;
                                end else if (w_tick_eff) begin
                                    if (r_time == w_term) begin
                                        r_state <= S_HALT;
                                        r_done  <= 1'b1;
                                    end else begin
                                        r_time <= w_stepped;
                                        if (w_stepped == w_term) begin
                                            r_state <= S_HALT;
                                            r_done  <= 1'b1;
                                        end
                                    end
                                end
                            end
                            S_HALT: begin
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign time_bcd = r_time;
    assign running  = (r_state == S_RUN);
    assign add_busy = (r_state == S_ADD1) || (r_state == S_ADD2);
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

    logic        clk = 1'b0;
    logic        Sreset;
    logic        tick;
    logic        run;
    logic        reverse;
    logic        load;
    logic [15:0] load_value;
    logic        add_req;
    logic [7:0]  add_min;
    logic [15:0] time_bcd;
    logic        running;
    logic        done;
    logic        add_busy;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_counter dut (
        .clk        (clk),
        .Sreset     (Sreset),
        .tick       (tick),
        .run        (run),
        .reverse    (reverse),
        .load       (load),
        .load_value (load_value),
        .add_req    (add_req),
        .add_min    (add_min),
        .time_bcd   (time_bcd),
        .running    (running),
        .done       (done),
        .add_busy   (add_busy),
        .load_err   (load_err)
    );

    // reference model: time kept as total seconds, modes as small integers
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_ADD1 = 3;
    localparam int M_ADD2 = 4;

    int  m_mode, m_ret, m_tot, m_add;
    bit  m_pend, m_armed, m_done, m_lerr;

    function automatic logic [15:0] to_bcd(int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] make_bcd(int m, int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_ret = M_IDLE; m_tot = 0; m_add = 0;
        m_pend = 0; m_armed = 0; m_done = 0; m_lerr = 0;
    endtask

    task automatic model_edge();
        int d3, d2, d1, d0, a10, a1, mins, secs, term;
        bit tk;
        m_done = 0;
        m_lerr = 0;
        if (m_mode == M_ADD1) begin
            if (tick) m_pend = 1;
            m_mode = M_ADD2;
        end else if (m_mode == M_ADD2) begin
            if (tick) m_pend = 1;
            a10  = m_add / 16;
            a1   = m_add % 16;
            mins = m_tot / 60;
            secs = m_tot % 60;
            if (a10 > 9 || a1 > 9) mins = 59;
            else mins = mins + a10 * 10 + a1;
            if (mins > 59) mins = 59;
            m_tot   = mins * 60 + secs;
            m_mode  = (m_ret == M_HALT) ? M_IDLE : m_ret;
            m_armed = m_pend && (m_mode == M_RUN);
            m_pend  = 0;
        end else begin
            tk = tick || m_armed;
            m_armed = 0;
            if (load) begin
                d3 = int'(load_value[15:12]); d2 = int'(load_value[11:8]);
                d1 = int'(load_value[7:4]);   d0 = int'(load_value[3:0]);
                if (d3 <= 9 && d2 <= 9 && d1 <= 5 && d0 <= 9 && (d3 * 10 + d2) <= 59) begin
                    m_tot  = (d3 * 10 + d2) * 60 + d1 * 10 + d0;
                    m_mode = M_IDLE;
                end else begin
                    m_lerr = 1;
                end
            end else if (add_req) begin
                m_add  = int'(add_min);
                m_ret  = m_mode;
                m_mode = M_ADD1;
            end else if (m_mode == M_IDLE) begin
                if (run) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (!run) m_mode = M_IDLE;
                else if (tk) begin
                    term = reverse ? 0 : 3599;
                    if (m_tot != term) m_tot = reverse ? m_tot - 1 : m_tot + 1;
                    if (m_tot == term) begin
                        m_mode = M_HALT;
                        m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        tick = 0; run = 0; reverse = 0; load = 0;
        load_value = 16'h0000; add_req = 0; add_min = 8'h00;
    endtask

    task automatic test_reset();
        Sreset = 1'b1;
        clear_inputs();
        step();
        step();
        Sreset = 1'b0;
        #1;
        n_checks++; if (time_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_time: got %h want %h", time_bcd, 16'h0000); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (add_busy !== 1'b0) begin n_fail++; $display("FAIL reset_add_busy: got %b want 0", add_busy); end
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    endtask

    task automatic test_count_down();
        load = 1; load_value = 16'h1020; step(); load = 0;
        n_checks++; if (time_bcd !== 16'h1020) begin n_fail++; $display("FAIL down_load: got %h want %h", time_bcd, 16'h1020); end
        run = 1; reverse = 1; step();
        for (int i = 0; i < 3; i++) begin
            tick = 1; step(); tick = 0; step();
        end
        n_checks++; if (time_bcd !== 16'h1017) begin n_fail++; $display("FAIL down_3ticks: got %h want %h", time_bcd, 16'h1017); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL down_running: got %b want 1", running); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL down_done: got %b want 0", done); end
        load = 1; load_value = 16'h0002; step(); load = 0;
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL down_load_idle: running %b want 0", running); end
        step();
        tick = 1; step(); tick = 0;
        n_checks++; if (time_bcd !== 16'h0001) begin n_fail++; $display("FAIL down_0001: got %h want %h", time_bcd, 16'h0001); end
        tick = 1; step(); tick = 0;
        n_checks++; if (time_bcd !== 16'h0000) begin n_fail++; $display("FAIL down_0000: got %h want %h", time_bcd, 16'h0000); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL down_done_pulse: got %b want 1", done); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL down_halt_running: got %b want 0", running); end
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL down_done_one_cycle: got %b want 0", done); end
        tick = 1; step(); tick = 0; step();
        n_checks++; if (time_bcd !== 16'h0000) begin n_fail++; $display("FAIL down_halt_frozen: got %h want %h", time_bcd, 16'h0000); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL down_halt_stays: running %b want 0", running); end
    endtask

    task automatic test_count_up();
        reverse = 0;
        load = 1; load_value = 16'h4959; step(); load = 0;
        step();
        tick = 1; step(); tick = 0;
        n_checks++; if (time_bcd !== 16'h5000) begin n_fail++; $display("FAIL up_carry: got %h want %h", time_bcd, 16'h5000); end
        load = 1; load_value = 16'h5958; step(); load = 0;
        step();
        tick = 1; step(); tick = 0;
        n_checks++; if (time_bcd !== 16'h5959) begin n_fail++; $display("FAIL up_terminal: got %h want %h", time_bcd, 16'h5959); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL up_done: got %b want 1", done); end
    endtask

    task automatic test_add_pending();
        load = 1; load_value = 16'h1230; step(); load = 0;
        step();
        add_req = 1; add_min = 8'h48; step(); add_req = 0;
        n_checks++; if (add_busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_c1: got %b want 1", add_busy); end
        tick = 1; step(); tick = 0;
        n_checks++; if (add_busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_c2: got %b want 1", add_busy); end
        step();
        n_checks++; if (add_busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_fall: got %b want 0", add_busy); end
        n_checks++; if (time_bcd !== 16'h5930) begin n_fail++; $display("FAIL add_saturate: got %h want %h", time_bcd, 16'h5930); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL add_return_run: got %b want 1", running); end
        step();
        n_checks++; if (time_bcd !== 16'h5931) begin n_fail++; $display("FAIL add_pending_tick: got %h want %h", time_bcd, 16'h5931); end
    endtask

    task automatic test_load_err();
        load = 1; load_value = 16'h1A00; step(); load = 0;
        n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL lerr_pulse: got %b want 1", load_err); end
        n_checks++; if (time_bcd !== 16'h5931) begin n_fail++; $display("FAIL lerr_time: got %h want %h", time_bcd, 16'h5931); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL lerr_state: running %b want 1", running); end
        step();
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL lerr_one_cycle: got %b want 0", load_err); end
        load = 1; add_req = 1; load_value = 16'h0500; add_min = 8'h11; step(); load = 0; add_req = 0;
        n_checks++; if (time_bcd !== 16'h0500) begin n_fail++; $display("FAIL load_beats_add: got %h want %h", time_bcd, 16'h0500); end
        n_checks++; if (add_busy !== 1'b0) begin n_fail++; $display("FAIL load_beats_add_busy: got %b want 0", add_busy); end
        step();
        n_checks++; if (add_busy !== 1'b0) begin n_fail++; $display("FAIL load_beats_add_busy2: got %b want 0", add_busy); end
    endtask

    task automatic test_reset_mid_add();
        add_req = 1; add_min = 8'h01; step(); add_req = 0;
        step();
        n_checks++; if (add_busy !== 1'b1) begin n_fail++; $display("FAIL rst_add_in_add2: got %b want 1", add_busy); end
        #2 Sreset = 1'b1;
        #1;
        n_checks++; if (time_bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_async_time: got %h want %h", time_bcd, 16'h0000); end
        n_checks++; if (add_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", add_busy); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL rst_async_running: got %b want 0", running); end
        Sreset = 1'b0;
        run = 0;
        step();
        n_checks++; if (running !== 1'b0 || time_bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_after: running %b time %h want 0 0000", running, time_bcd); end
    endtask

    task automatic test_random();
        logic [15:0] exp_time;
        Sreset = 1'b1; clear_inputs(); step(); Sreset = 1'b0;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            tick    = ($urandom_range(0, 2) != 0);
            run     = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 39) == 0) reverse = ~reverse;
            load    = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0: load_value = 16'($urandom);
                1: load_value = make_bcd(0, int'($urandom_range(0, 5)));
                2: load_value = make_bcd(59, int'($urandom_range(50, 59)));
                default: load_value = make_bcd(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
            endcase
            add_req = ($urandom_range(0, 24) == 0);
            add_min = ($urandom_range(0, 4) == 0) ? 8'($urandom) :
                      {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            model_edge();
            step();
            exp_time = to_bcd(m_tot);
            if (m_mode != M_ADD2) begin
                n_checks++; if (time_bcd !== exp_time) begin n_fail++; $display("FAIL rnd_time c=%0d: got %h want %h", c, time_bcd, exp_time); end
            end
            n_checks++; if (running !== (m_mode == M_RUN)) begin n_fail++; $display("FAIL rnd_running c=%0d: got %b want %b", c, running, (m_mode == M_RUN)); end
            n_checks++; if (add_busy !== (m_mode == M_ADD1 || m_mode == M_ADD2)) begin n_fail++; $display("FAIL rnd_add_busy c=%0d: got %b want %0d", c, add_busy, int'(m_mode == M_ADD1 || m_mode == M_ADD2)); end
            n_checks++; if (done !== m_done) begin n_fail++; $display("FAIL rnd_done c=%0d: got %b want %b", c, done, m_done); end
            n_checks++; if (load_err !== m_lerr) begin n_fail++; $display("FAIL rnd_load_err c=%0d: got %b want %b", c, load_err, m_lerr); end
        end
    endtask

    initial begin
        test_reset();
        test_count_down();
        test_count_up();
        test_add_pending();
        test_load_err();
        test_reset_mid_add();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
